frame_serializer: RTL

- Receiving end of the processing-function output interface: captures a parallel frame of NB_WORDS x 32-bit words, qualified by a one-cycle enable pulse, and streams it out one word per cycle over a valid/ready handshake.
- Sits between the processing block (funct) and the host-side streaming link (UART/AXI-Stream bridge).
- Holds one active frame plus one pending frame, so back-to-back results are not lost while the link stalls.

---
 rtl/funct_pkg.sv | 12 +
 rtl/frame_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/funct_pkg.sv
// Shared types for the processing-function output path.
// Word width and serializer state encoding.
package funct_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

endpackage

// File: rtl/frame_serializer.sv
// Captures a parallel frame on a one-cycle pulse and streams it word by word.
// One active plus one pending frame; further frames are dropped and counted.
module frame_serializer
    import funct_pkg::*;
#(
    parameter int NB_WORDS = 1,
    parameter int CNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_en,
    input  logic [0:NB_WORDS-1][WORD_W-1:0]     in_data,
    output logic                                out_valid,
    output logic [WORD_W-1:0]                   out_data,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                busy,
    output logic                                overflow,
    output logic [CNT_W-1:0]                    drop_cnt
);

    typedef logic [0:NB_WORDS-1][WORD_W-1:0] frame_t;

    localparam int IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    frame_t           act_q, act_d;
    frame_t           pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic xfer;
    logic last_w;
    logic done;

    assign xfer   = (state_q == SEND) && out_ready;
    assign last_w = (idx_q == LAST_IDX);
    assign done   = xfer && last_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_en) begin
                    act_d   = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (done) begin
                    // Refill from pending first so a simultaneous pulse lands in pending.
                    if (pend_v_q) begin
                        act_d    = pend_q;
                        idx_d    = '0;
                        pend_v_d = in_en;
                        if (in_en) pend_d = in_data;
                    end else if (in_en) begin
                        act_d = in_data;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    if (xfer) idx_d = idx_q + IDX_W'(1);
                    if (in_en) begin
                        if (!pend_v_q) begin
                            pend_d   = in_data;
                            pend_v_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = '0;
        if (state_q == SEND) begin
            for (int i = 0; i < NB_WORDS; i++) begin
                if (idx_q == IDX_W'(i)) out_data = act_q[i];
            end
        end
        out_last = (state_q == SEND) && last_w;
        busy     = (state_q == SEND) || pend_v_q;
        overflow = ovf_q;
        drop_cnt = cnt_q;
    end

endmodule
